// File: rtl/spi_bit_sampler_pkg.sv
// Shared types and constants for the SPI bit sampler.
// Optional build macro: SPI_BIT_SAMPLER_GLITCH_FILTER_EN (sck majority filter).
package spi_bit_sampler_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_CNT_W     = 3;
    localparam int unsigned BYTE_CNT_W    = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Two-out-of-three vote used by the optional sck glitch filter.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_ff #(
    parameter int unsigned N       = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] stg_q;

    // Shift the asynchronous input through N flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_q <= {N{RST_VAL}};
        end else begin
            stg_q <= {stg_q[N-2:0], d_i};
        end
    end

    assign q_o = stg_q[N-1];

endmodule

// File: rtl/spi_bit_sampler.sv
// SPI bit sampler: synchronizes sck/sdi/cs_n, frames on cs_n and emits one
// bit strobe per sck rising edge plus byte/frame status pulses.
// Optional build macro: SPI_BIT_SAMPLER_GLITCH_FILTER_EN adds a 3-sample
// majority filter on sck (and a matching extra sdi stage).
module spi_bit_sampler
    import spi_bit_sampler_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck_in,
    input  logic                  sdi_in,
    input  logic                  cs_n_in,
    output logic                  bit_data,
    output logic                  bit_en,
    output logic                  frame_clr,
    output logic                  byte_done,
    output logic                  frame_err,
    output logic                  busy,
    output logic [BYTE_CNT_W-1:0] byte_count
);

    logic sck_s, sdi_s, cs_s;
    logic sck_f, sdi_f;

    sync_ff #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .d_i(sck_in), .q_o(sck_s)
    );
    sync_ff #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .reset(reset), .d_i(sdi_in), .q_o(sdi_s)
    );
    sync_ff #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d_i(cs_n_in), .q_o(cs_s)
    );

`ifdef SPI_BIT_SAMPLER_GLITCH_FILTER_EN
    logic sck_h1_q, sck_h2_q, sdi_h_q;

    // Sample history for the sck vote; sdi is delayed by the same one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_h1_q <= 1'b0;
            sck_h2_q <= 1'b0;
            sdi_h_q  <= 1'b0;
        end else begin
            sck_h1_q <= sck_s;
            sck_h2_q <= sck_h1_q;
            sdi_h_q  <= sdi_s;
        end
    end

    assign sck_f = maj3(sck_s, sck_h1_q, sck_h2_q);
    assign sdi_f = sdi_h_q;
`else
    assign sck_f = sck_s;
    assign sdi_f = sdi_s;
`endif

    logic                   sck_prev_q, cs_prev_q, armed_q;
    logic [SYNC_STAGES-1:0] settled_q;
    logic                   sck_rise, cs_fall, cs_rise;

    // Edge history, plus arming: after reset a frame may only start once
    // cs_n has been seen high on a synchronizer output refilled from real input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            settled_q  <= '0;
            armed_q    <= 1'b0;
        end else begin
            sck_prev_q <= sck_f;
            cs_prev_q  <= cs_s;
            settled_q  <= {settled_q[SYNC_STAGES-2:0], 1'b1};
            armed_q    <= armed_q | (settled_q[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sck_rise = sck_f & ~sck_prev_q;
    assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev_q;

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0]  byte_count_q, byte_count_d;
    logic                   bit_en_q, bit_en_d;
    logic                   bit_data_q, bit_data_d;
    logic                   frame_clr_q, frame_clr_d;
    logic                   byte_done_q, byte_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;

    // Framing FSM: next state, counters and registered output pulses.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_count_d = byte_count_q;
        bit_en_d     = 1'b0;
        bit_data_d   = 1'b0;
        frame_clr_d  = 1'b0;
        byte_done_d  = 1'b0;
        frame_err_d  = 1'b0;

        // Counter already wrapped to zero while the 8th strobe is out.
        if (bit_en_q && (bit_cnt_q == '0)) begin
            byte_done_d  = 1'b1;
            byte_count_d = byte_count_q + BYTE_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d      = ST_ACTIVE;
                    frame_clr_d  = 1'b1;
                    bit_cnt_d    = '0;
                    byte_count_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sck_rise) begin
                    bit_en_d   = 1'b1;
                    bit_data_d = sdi_f;
                    bit_cnt_d  = (bit_cnt_q == BIT_CNT_W'(BITS_PER_BYTE - 1))
                                 ? '0 : bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACTIVE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            byte_count_q <= '0;
            bit_en_q     <= 1'b0;
            bit_data_q   <= 1'b0;
            frame_clr_q  <= 1'b0;
            byte_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_count_q <= byte_count_d;
            bit_en_q     <= bit_en_d;
            bit_data_q   <= bit_data_d;
            frame_clr_q  <= frame_clr_d;
            byte_done_q  <= byte_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bit_data   = bit_data_q;
    assign bit_en     = bit_en_q;
    assign frame_clr  = frame_clr_q;
    assign byte_done  = byte_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_spi_bit_sampler.sv
// Directed testbench for spi_bit_sampler (SYNC_STAGES = 2).
// Build with SPI_BIT_SAMPLER_GLITCH_FILTER_EN to also exercise the sck filter.
module tb_spi_bit_sampler;

    localparam int unsigned SYNC_STAGES = 2;
`ifdef SPI_BIT_SAMPLER_GLITCH_FILTER_EN
    localparam int EXP_LAT = SYNC_STAGES + 2;
`else
    localparam int EXP_LAT = SYNC_STAGES + 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sck_in, sdi_in, cs_n_in;
    logic       bit_data, bit_en, frame_clr, byte_done, frame_err, busy;
    logic [7:0] byte_count;

    spi_bit_sampler #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .reset(reset), .sck_in(sck_in), .sdi_in(sdi_in),
        .cs_n_in(cs_n_in), .bit_data(bit_data), .bit_en(bit_en),
        .frame_clr(frame_clr), .byte_done(byte_done), .frame_err(frame_err),
        .busy(busy), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          n_bit_en, n_clr, n_done, n_err;
    int          n_wide = 0;
    int          n_overlap = 0;
    logic [23:0] rx24;
    logic        p_en = 1'b0, p_clr = 1'b0, p_done = 1'b0, p_err = 1'b0;
    int          lat;
    logic        found;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clr_obs();
        n_bit_en = 0; n_clr = 0; n_done = 0; n_err = 0; rx24 = '0;
    endtask

    // One clock; observe outputs 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bit_en) begin
            n_bit_en++;
            rx24 = {bit_data, rx24[23:1]};
        end
        if (frame_clr) n_clr++;
        if (byte_done) n_done++;
        if (frame_err) n_err++;
        if (bit_en && frame_clr) n_overlap++;
        if ((bit_en && p_en) || (frame_clr && p_clr) || (byte_done && p_done) || (frame_err && p_err))
            n_wide++;
        p_en = bit_en; p_clr = frame_clr; p_done = byte_done; p_err = frame_err;
    endtask

    task automatic send_bit(input logic b);
        sdi_in = b;
        sck_in = 1'b0;
        repeat (4) step();
        sck_in = 1'b1;
        repeat (4) step();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic cs_low();
        cs_n_in = 1'b0;
        repeat (6) step();
    endtask

    task automatic cs_high();
        sck_in  = 1'b0;
        cs_n_in = 1'b1;
        repeat (6) step();
    endtask

    initial begin
        reset = 1'b0; sck_in = 1'b0; sdi_in = 1'b0; cs_n_in = 1'b1;
        clr_obs();
        repeat (3) step();
        check("reset_outputs", 32'({bit_data, bit_en, frame_clr, byte_done, frame_err, busy, byte_count}), 32'h0);
        reset = 1'b1;
        repeat (6) step();
        check("idle_after_reset_busy", 32'(busy), 32'h0);

        // Single byte 0xA5, LSB first.
        clr_obs();
        cs_low();
        check("a5_frame_clr", 32'(n_clr), 32'd1);
        check("a5_busy", 32'(busy), 32'd1);
        send_byte(8'hA5);
        repeat (2) step();
        check("a5_bit_en_count", 32'(n_bit_en), 32'd8);
        check("a5_data", 32'(rx24[23:16]), 32'hA5);
        check("a5_byte_done", 32'(n_done), 32'd1);
        check("a5_byte_count", 32'(byte_count), 32'd1);
        cs_high();
        check("a5_no_frame_err", 32'(n_err), 32'd0);
        check("a5_idle_busy", 32'(busy), 32'd0);

        // Three back-to-back bytes.
        clr_obs();
        cs_low();
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'h80);
        repeat (2) step();
        check("b3_bit_en_count", 32'(n_bit_en), 32'd24);
        check("b3_data", 32'(rx24), 32'h80FF01);
        check("b3_byte_done", 32'(n_done), 32'd3);
        check("b3_byte_count", 32'(byte_count), 32'd3);
        cs_high();
        check("b3_no_frame_err", 32'(n_err), 32'd0);

        // Frame aborted after 5 bits, then sck activity while idle.
        clr_obs();
        cs_low();
        check("abort_count_cleared", 32'(byte_count), 32'd0);
        for (int i = 0; i < 5; i++) send_bit(1'(i % 2 == 0));
        cs_high();
        check("abort_bits", 32'(n_bit_en), 32'd5);
        check("abort_frame_err", 32'(n_err), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        clr_obs();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("idle_sck_ignored", 32'(n_bit_en), 32'd0);

        // cs_n rising together with the 8th sck edge.
        clr_obs();
        cs_low();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        sck_in = 1'b0;
        repeat (4) step();
        sck_in  = 1'b1;
        cs_n_in = 1'b1;
        repeat (6) step();
        check("coinc_bits", 32'(n_bit_en), 32'd7);
        check("coinc_frame_err", 32'(n_err), 32'd1);
        check("coinc_no_byte_done", 32'(n_done), 32'd0);
        check("coinc_byte_count", 32'(byte_count), 32'd0);

        // Reset mid-frame with cs_n held low through release.
        clr_obs();
        cs_low();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        reset = 1'b0;
        #1;
        check("midrst_outputs", 32'({bit_data, bit_en, frame_clr, byte_done, frame_err, busy, byte_count}), 32'h0);
        repeat (3) step();
        reset = 1'b1;
        repeat (6) step();
        check("midrst_no_frame_err", 32'(n_err), 32'd0);
        check("midrst_stays_idle", 32'(busy), 32'd0);
        clr_obs();
        send_bit(1'b1); send_bit(1'b0);
        check("midrst_needs_fresh_cs", 32'(n_bit_en), 32'd0);
        cs_high();
        clr_obs();
        cs_low();
        send_byte(8'h3C);
        repeat (2) step();
        check("rx3c_frame_clr", 32'(n_clr), 32'd1);
        check("rx3c_data", 32'(rx24[23:16]), 32'h3C);
        check("rx3c_byte_done", 32'(n_done), 32'd1);
        check("rx3c_byte_count", 32'(byte_count), 32'd1);
        cs_high();
        check("rx3c_no_frame_err", 32'(n_err), 32'd0);

        // sck-to-bit_en latency, counted in rising edges including the sampling edge.
        clr_obs();
        cs_low();
        sdi_in = 1'b1;
        sck_in = 1'b0;
        repeat (4) step();
        sck_in = 1'b1;
        lat = 0; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            lat++;
            if (bit_en) found = 1'b1;
        end
        check("lat_seen", 32'(found), 32'd1);
        check("lat_cycles", 32'(lat), 32'(EXP_LAT));
        check("lat_bit_data", 32'(bit_data), 32'd1);
        repeat (3) step();
`ifdef SPI_BIT_SAMPLER_GLITCH_FILTER_EN
        // One-cycle sck pulse must be voted out.
        sck_in = 1'b0;
        repeat (4) step();
        clr_obs();
        sck_in = 1'b1;
        step();
        sck_in = 1'b0;
        repeat (6) step();
        check("glitch_no_bit_en", 32'(n_bit_en), 32'd0);
`endif
        clr_obs();
        cs_high();
        check("lat_frame_err", 32'(n_err), 32'd1);

        check("pulse_width", 32'(n_wide), 32'd0);
        check("clr_bit_en_overlap", 32'(n_overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
